// File: rtl/button_event_gen.sv
// ---------------------------------------------------------------------------
// button_event_gen
//
// Turns a debounced, clock-synchronous button level into single-cycle UI
// events for downstream game/menu logic: press, release, long-press (hold)
// and auto-repeat. All outputs are registered.
//
// Optional feature macro: BUTTON_REPEAT_EN
//   defined     : repeat_out pulses on press and every REPEAT_CYCLES while held
//   not defined : repeat_out is tied low and the HELD state does not count
//
// Parameters
//   HOLD_CYCLES   : press duration (cycles) before the hold event fires, >= 2
//   REPEAT_CYCLES : auto-repeat period (cycles) while held, >= 2
//   CNT_W         : counter width, >= clog2(max(HOLD_CYCLES, REPEAT_CYCLES))
//
// Ports
//   clock_in    : system clock, rising edge
//   reset_in    : asynchronous, active-low reset
//   clean_in    : debounced button level, 1 = pressed
//   press_out   : one-cycle pulse on the press edge
//   release_out : one-cycle pulse on the release edge
//   hold_out    : one-cycle pulse when the press reaches HOLD_CYCLES
//   repeat_out  : one-cycle pulse on press and every repeat period while held
//   held_out    : level, high while in the HELD state
// ---------------------------------------------------------------------------
module button_event_gen #(
    parameter int HOLD_CYCLES   = 65_000_000,
    parameter int REPEAT_CYCLES = 6_500_000,
    parameter int CNT_W         = 27
) (
    input  logic clock_in,
    input  logic reset_in,
    input  logic clean_in,
    output logic press_out,
    output logic release_out,
    output logic hold_out,
    output logic repeat_out,
    output logic held_out
);

    // Elaboration-time sanity check of the parameter set. The counter must
    // be able to represent the largest terminal count it is compared with.
    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                              : REPEAT_CYCLES;

    generate
        if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2 || CNT_W < $clog2(MAX_CYCLES))
        begin : g_bad_params
            $error("button_event_gen: invalid HOLD_CYCLES/REPEAT_CYCLES/CNT_W");
        end
    endgenerate

    // Terminal counts pre-sized to the counter width so compares are exact.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
`ifdef BUTTON_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             press_next;
    logic             release_next;
    logic             hold_next;
    logic             repeat_next;
    logic             held_next;

    // State, counter and every output are registered together, so each event
    // appears exactly one edge after the input level that caused it. Reset
    // clears everything asynchronously, which drops held_out immediately.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= IDLE;
            cnt         <= '0;
            press_out   <= 1'b0;
            release_out <= 1'b0;
            hold_out    <= 1'b0;
            repeat_out  <= 1'b0;
            held_out    <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            press_out   <= press_next;
            release_out <= release_next;
            hold_out    <= hold_next;
            repeat_out  <= repeat_next;
            held_out    <= held_next;
        end
    end

    // Next-state and next-output logic. A release is tested before any
    // threshold, so on the release cycle no hold or repeat pulse can fire.
    // Every threshold match also clears the counter, so it never wraps.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        hold_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state)
            IDLE: begin
                if (clean_in) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    press_next = 1'b1;
`ifdef BUTTON_REPEAT_EN
                    repeat_next = 1'b1;
`endif
                end
            end

            PRESSED: begin
                if (!clean_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    hold_next  = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end

            HELD: begin
                if (!clean_in) begin
                    state_next   = IDLE;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else begin
`ifdef BUTTON_REPEAT_EN
                    if (cnt == REPEAT_LAST) begin
                        repeat_next = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
`else
                    // Without auto-repeat there is nothing to time in HELD.
                    cnt_next = '0;
`endif
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // held_out mirrors the registered state, so it rises with hold_out
        // and falls on the same edge that raises release_out.
        held_next = (state_next == HELD);
    end

endmodule

// File: tb/tb_button_event_gen.sv
// ---------------------------------------------------------------------------
// tb_button_event_gen
//
// Self-checking bench for button_event_gen with HOLD_CYCLES=8,
// REPEAT_CYCLES=4, CNT_W=4. A table of {clean_in, expected outputs} records
// covers short, long, threshold-release and one-cycle presses; hand-written
// sequences cover reset during HELD and a button held down through reset.
// Expected repeat pulses follow the BUTTON_REPEAT_EN build setting.
// ---------------------------------------------------------------------------
module tb_button_event_gen;

    localparam int HOLD_CYCLES   = 8;
    localparam int REPEAT_CYCLES = 4;
    localparam int CNT_W         = 4;

`ifdef BUTTON_REPEAT_EN
    localparam logic REP = 1'b1;
`else
    localparam logic REP = 1'b0;
`endif

    logic clock_in;
    logic reset_in;
    logic clean_in;
    logic press_out;
    logic release_out;
    logic hold_out;
    logic repeat_out;
    logic held_out;

    int check_count = 0;
    int error_count = 0;

    // Expected output vector order: {press, release, hold, repeat, held}
    typedef struct {
        logic       clean;
        logic [4:0] expect_out;
        string      name;
    } vec_t;

    vec_t vecs[$];

    button_event_gen #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES),
        .CNT_W        (CNT_W)
    ) dut (
        .clock_in   (clock_in),
        .reset_in   (reset_in),
        .clean_in   (clean_in),
        .press_out  (press_out),
        .release_out(release_out),
        .hold_out   (hold_out),
        .repeat_out (repeat_out),
        .held_out   (held_out)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    // Compare the five outputs against an expected vector.
    task automatic check_output(input string name, input logic [4:0] expect_out);
        logic [4:0] got;
        got = {press_out, release_out, hold_out, repeat_out, held_out};
        check_count++;
        if (got !== expect_out) begin
            error_count++;
            $display("[TB] FAIL %s at %0t: got {p,r,h,rp,hd}=%b expected %b",
                     name, $time, got, expect_out);
        end
    endtask

    // Drive clean_in away from the edge, then sample 1 unit after the edge.
    task automatic apply_stimulus(input logic clean);
        clean_in = clean;
        @(posedge clock_in);
        #1;
    endtask

    task automatic add_vec(input logic clean, input logic [4:0] e, input string name);
        vec_t v;
        v.clean      = clean;
        v.expect_out = e;
        v.name       = name;
        vecs.push_back(v);
    endtask

    initial begin
        reset_in = 1'b0;
        clean_in = 1'b0;

        // Reset held with clean_in toggling: outputs stay 0.
        for (int i = 0; i < 6; i++) begin
            apply_stimulus((i % 2) == 1);
            check_output("reset_hold", 5'b00000);
        end

        clean_in = 1'b0;
        reset_in = 1'b1;
        apply_stimulus(1'b0);
        check_output("idle_after_reset", 5'b00000);

        // Short press: 3 cycles high, release at N+3.
        add_vec(1'b1, {1'b1, 1'b0, 1'b0, REP, 1'b0}, "short_press");
        add_vec(1'b1, 5'b00000, "short_mid1");
        add_vec(1'b1, 5'b00000, "short_mid2");
        add_vec(1'b0, 5'b01000, "short_release");
        add_vec(1'b0, 5'b00000, "short_after");

        // Long press: 20 cycles high. Hold at N+8, repeats at N+12, N+16,
        // the would-be repeat at N+20 is swallowed by the release.
        add_vec(1'b1, {1'b1, 1'b0, 1'b0, REP, 1'b0}, "long_press");
        for (int i = 1; i <= 7; i++) add_vec(1'b1, 5'b00000, "long_pre_hold");
        add_vec(1'b1, 5'b00101, "long_hold");
        for (int i = 9; i <= 11; i++) add_vec(1'b1, 5'b00001, "long_held");
        add_vec(1'b1, {1'b0, 1'b0, 1'b0, REP, 1'b1}, "long_repeat1");
        for (int i = 13; i <= 15; i++) add_vec(1'b1, 5'b00001, "long_held");
        add_vec(1'b1, {1'b0, 1'b0, 1'b0, REP, 1'b1}, "long_repeat2");
        for (int i = 17; i <= 19; i++) add_vec(1'b1, 5'b00001, "long_held");
        add_vec(1'b0, 5'b01000, "long_release");
        add_vec(1'b0, 5'b00000, "long_after");

        // Release exactly on the hold threshold: release wins, no hold.
        add_vec(1'b1, {1'b1, 1'b0, 1'b0, REP, 1'b0}, "thr_press");
        for (int i = 1; i <= 7; i++) add_vec(1'b1, 5'b00000, "thr_pre");
        add_vec(1'b0, 5'b01000, "thr_release");
        add_vec(1'b0, 5'b00000, "thr_after");

        // One-cycle press: press then release on the next edge.
        add_vec(1'b1, {1'b1, 1'b0, 1'b0, REP, 1'b0}, "one_press");
        add_vec(1'b0, 5'b01000, "one_release");
        add_vec(1'b0, 5'b00000, "one_after");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].clean);
            check_output(vecs[i].name, vecs[i].expect_out);
        end

        // Reset asserted while in HELD: held_out drops before the next edge.
        apply_stimulus(1'b1);
        check_output("rst_held_press", {1'b1, 1'b0, 1'b0, REP, 1'b0});
        for (int i = 1; i <= 7; i++) apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        check_output("rst_held_hold", 5'b00101);
        #2;
        reset_in = 1'b0;
        #1;
        check_output("rst_async_drop", 5'b00000);

        // Button stays down through reset: fresh press at the first edge.
        apply_stimulus(1'b1);
        check_output("rst_down_in_reset", 5'b00000);
        reset_in = 1'b1;
        apply_stimulus(1'b1);
        check_output("rst_down_press", {1'b1, 1'b0, 1'b0, REP, 1'b0});
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(1'b1);
            check_output("rst_down_pre_hold", 5'b00000);
        end
        apply_stimulus(1'b1);
        check_output("rst_down_hold", 5'b00101);
        apply_stimulus(1'b0);
        check_output("rst_down_release", 5'b01000);
        apply_stimulus(1'b0);
        check_output("rst_down_after", 5'b00000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/button_event_gen.md
# button_event_gen

Converts a debounced, clock-synchronous button level into single-cycle UI events: press, release, long-press (hold) and auto-repeat. One instance sits downstream of each button's debouncer and feeds the game/menu logic, which consumes pulses instead of levels. All outputs are registered. `clean_in` must already be glitch-free and synchronous to `clock_in`.

## Interface
- `HOLD_CYCLES`, default 65_000_000: press duration in cycles before the hold event fires (1 s at 65 MHz). Must be ≥ 2.
- `REPEAT_CYCLES`, default 6_500_000: auto-repeat period in cycles while held (100 ms). Must be ≥ 2.
- `CNT_W`, default 27: counter width. Must be ≥ clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).

- `clock_in` in 1: system clock; all logic on the rising edge.
- `reset_in` in 1: asynchronous, active-low reset.
- `clean_in` in 1: debounced button level, 1 = pressed.
- `press_out` out 1: one-cycle pulse on the press edge.
- `release_out` out 1: one-cycle pulse on the release edge.
- `hold_out` out 1: one-cycle pulse when the press reaches `HOLD_CYCLES`.
- `repeat_out` out 1: one-cycle pulse on press and at every repeat period while held (see Configuration).
- `held_out` out 1: level, 1 while in HELD.

## Operation
- States:
  - IDLE: button up.
  - PRESSED: down, hold threshold not yet reached.
  - HELD: down past the hold threshold.
- Counter `cnt` is CNT_W bits wide and unsigned. It never wraps, because every compare resets it.
- IDLE, `clean_in`=1: go to PRESSED, `cnt`←0, `press_out`←1, `repeat_out`←1.
- PRESSED, `clean_in`=0: go to IDLE, `release_out`←1, `cnt`←0.
- PRESSED, `clean_in`=1, `cnt`==HOLD_CYCLES−1: go to HELD, `cnt`←0, `hold_out`←1, `held_out`←1.
- PRESSED, otherwise: `cnt`←`cnt`+1.
- HELD, `clean_in`=0: go to IDLE, `release_out`←1, `held_out`←0, `cnt`←0.
- HELD, `cnt`==REPEAT_CYCLES−1: `repeat_out`←1, `cnt`←0.
- HELD, otherwise: `cnt`←`cnt`+1.
- Pulse outputs default to 0 every cycle unless set by the rules above.
- Simultaneous events: release has priority over any threshold in the same cycle. No hold or repeat pulse is emitted on the release cycle.
- `press_out` and `release_out` are never high in the same cycle.
- A press lasting exactly one cycle produces `press_out` followed by `release_out` on the next cycle.

## Timing
- Reset: all outputs 0, state IDLE, `cnt` 0. Reset takes effect immediately when asserted, including mid-HOLD (held_out drops asynchronously).
- Let edge N be the first rising edge where `clean_in`=1 is sampled while in IDLE.
- `press_out` and `repeat_out` are high from edge N to edge N+1. Latency is 1 edge.
- `hold_out` and `held_out` rise at edge N+HOLD_CYCLES.
- Repeat pulses occur at edge N+HOLD_CYCLES+k·REPEAT_CYCLES, for k ≥ 1.
- If `clean_in`=0 is first sampled at edge M, `release_out` is high from edge M to edge M+1, and `held_out` falls at edge M.
- If `clean_in`=1 when reset deasserts, it is treated as a fresh press: `press_out` fires at the first edge after deassertion.

## Configuration
- Macro `BUTTON_REPEAT_EN`.
- Defined: auto-repeat behaves as described in Operation.
- Not defined:
  - `repeat_out` is tied to 0, including on press.
  - HELD does not count (`cnt` stays 0).
  - `hold_out`, `held_out`, `press_out` and `release_out` are unchanged.

## Test plan
Parameters for all tests: HOLD_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4, macro defined unless stated.

1. Reset: hold `reset_in`=0 with `clean_in` toggling → all outputs 0. Then assert reset while in HELD → `held_out` drops to 0 before the next clock edge.
2. Short press: `clean_in`=1 for 3 cycles from edge N → `press_out` and `repeat_out` pulse at N, `release_out` pulse at N+3, no `hold_out`.
3. Long press: `clean_in`=1 for 20 cycles from edge N → `hold_out` pulse and `held_out` rise at N+8, `repeat_out` at N, N+12 and N+16, `release_out` and `held_out` fall at N+20.
4. Release on the threshold: `clean_in` falls so that 0 is sampled at edge N+8 → `release_out` at N+8, `hold_out` never asserts, `held_out` stays 0.
5. Macro undefined, repeat scenario 3 → `repeat_out` stays 0 throughout; hold and release timing identical to scenario 3.
6. Button down through reset: `clean_in`=1 when reset deasserts → `press_out` at the first edge, `hold_out` 8 edges later.
